// File: rtl/f_mul_pkg.sv
// Shared types for the radix-4 Booth sequential multiplier.
// Holds the FSM state encoding, the Booth digit codes and the digit decoder.
package f_mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    DG_ZERO = 3'd0,
    DG_PA   = 3'd1,
    DG_P2A  = 3'd2,
    DG_MA   = 3'd3,
    DG_M2A  = 3'd4
  } digit_e;

  // Window is {b[2k+1], b[2k], b[2k-1]}.
  function automatic digit_e booth_digit(input logic [2:0] w);
    digit_e d;
    unique case (w)
      3'b000, 3'b111: d = DG_ZERO;
      3'b001, 3'b010: d = DG_PA;
      3'b011:         d = DG_P2A;
      3'b100:         d = DG_M2A;
      3'b101, 3'b110: d = DG_MA;
      default:        d = DG_ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth4code_gold.sv
// Radix-4 Booth partial-product generator.
// Ports: i_a (sign-extended multiplicand, length bits), i_dig (digit), o_pp (length+1 bits).
module booth4code_gold
  import f_mul_pkg::*;
#(
  parameter int length = 33
) (
  input  logic [length-1:0] i_a,
  input  digit_e            i_dig,
  output logic [length:0]   o_pp
);

  logic [length:0] w_a1;
  logic [length:0] w_a2;

  // One extra bit so that +/-2A never overflows.
  assign w_a1 = {i_a[length-1], i_a};
  assign w_a2 = {i_a, 1'b0};

  always_comb begin
    o_pp = '0;
    unique case (i_dig)
      DG_ZERO: o_pp = '0;
      DG_PA:   o_pp = w_a1;
      DG_P2A:  o_pp = w_a2;
      DG_MA:   o_pp = -w_a1;
      DG_M2A:  o_pp = -w_a2;
      default: o_pp = '0;
    endcase
  end

endmodule

// File: rtl/booth4_seq_mul.sv
// Sequential signed multiplier, one radix-4 Booth digit per cycle.
// Ports: CLK, rst_n, in_valid_i/in_ready_o/a_i/b_i (operands),
//   out_valid_o/out_ready_i/product_o (result), busy_o.
module booth4_seq_mul
  import f_mul_pkg::*;
#(
  parameter int LENGTH = 32
) (
  input  logic                CLK,
  input  logic                rst_n,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [LENGTH-1:0]   a_i,
  input  logic [LENGTH-1:0]   b_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [2*LENGTH-1:0] product_o,
  output logic                busy_o
);

  localparam int CW = $clog2(LENGTH/2);
  localparam logic [CW-1:0] LAST = CW'(LENGTH/2 - 1);

  state_e                r_state;
  state_e                w_next;
  logic [LENGTH-1:0]     r_a;
  logic [LENGTH-1:0]     r_b;
  logic                  r_bm1;
  logic [CW-1:0]         r_cnt;
  logic [2*LENGTH-1:0]   r_acc;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic                  r_busy;

  logic                  w_accept;
  digit_e                w_dig;
  logic [LENGTH+1:0]     w_pp;
  logic [2*LENGTH-1:0]   w_pp_ext;
  logic [2*LENGTH-1:0]   w_pp_sh;

  // r_in_ready gates acceptance so nothing is taken before
  // the first edge after reset release.
  assign w_accept = (r_state == ST_IDLE) && in_valid_i && r_in_ready;

  assign w_dig = booth_digit({r_b[1], r_b[0], r_bm1});

  booth4code_gold #(
    .length(LENGTH + 1)
  ) u_pp (
    .i_a  ({r_a[LENGTH-1], r_a}),
    .i_dig(w_dig),
    .o_pp (w_pp)
  );

  assign w_pp_ext = {{(LENGTH-2){w_pp[LENGTH+1]}}, w_pp};
  assign w_pp_sh  = w_pp_ext << {r_cnt, 1'b0};

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_accept) w_next = ST_RUN;
      ST_RUN:  if (r_cnt == LAST) w_next = ST_DONE;
      ST_DONE: if (r_out_valid && out_ready_i) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_bm1 <= 1'b0;
      r_cnt <= '0;
      r_acc <= '0;
    end else if (w_accept) begin
      r_a   <= a_i;
      r_b   <= b_i;
      r_bm1 <= 1'b0;
      r_cnt <= '0;
      r_acc <= '0;
    end else if (r_state == ST_RUN) begin
      r_acc <= r_acc + w_pp_sh;
      r_b   <= {2'b00, r_b[LENGTH-1:2]};
      r_bm1 <= r_b[1];
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
    end
  end

  // Flags are registered from the next state; out_valid
  // rises one cycle after entering DONE.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_in_ready  <= (w_next == ST_IDLE);
      r_out_valid <= (r_state == ST_DONE) && (w_next == ST_DONE);
      r_busy      <= (w_next != ST_IDLE);
    end
  end

  assign in_ready_o  = r_in_ready;
  assign out_valid_o = r_out_valid;
  assign busy_o      = r_busy;
  assign product_o   = r_acc;

endmodule

// File: tb/tb_booth4_seq_mul.sv
// Directed self-checking bench for booth4_seq_mul, LENGTH = 32.
// Hand-computed products, latency, handshake and reset behaviour.
module tb_booth4_seq_mul;

  logic        CLK = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [63:0] product_o;
  logic        busy_o;

  int n_chk = 0;
  int n_err = 0;

  booth4_seq_mul #(.LENGTH(32)) dut (
    .CLK        (CLK),
    .rst_n      (rst_n),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .a_i        (a_i),
    .b_i        (b_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .product_o  (product_o),
    .busy_o     (busy_o)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready_o && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("ready", 64'(in_ready_o), 64'd1);
  endtask

  task automatic do_mul(input string tag, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp,
                        input int hold);
    int n;
    logic [63:0] p;
    bit ok;
    wait_ready();
    a_i = a;
    b_i = b;
    in_valid_i = 1'b1;
    @(posedge CLK); #1;
    in_valid_i = 1'b0;
    chk({tag, ".busy"}, 64'({busy_o, in_ready_o}), 64'b10);
    n = 0;
    while (!out_valid_o && n < 40) begin
      in_valid_i = n[0];
      a_i = $urandom;
      b_i = $urandom;
      @(posedge CLK); #1;
      n++;
    end
    in_valid_i = 1'b0;
    chk({tag, ".lat"}, 64'(n), 64'd17);
    chk({tag, ".prod"}, product_o, exp);
    p = product_o;
    ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      in_valid_i = 1'b1;
      a_i = $urandom;
      @(posedge CLK); #1;
      if (product_o !== p || out_valid_o !== 1'b1 || in_ready_o !== 1'b0)
        ok = 1'b0;
    end
    in_valid_i = 1'b0;
    if (hold > 0) chk({tag, ".hold"}, 64'(ok), 64'd1);
    out_ready_i = 1'b1;
    @(posedge CLK); #1;
    out_ready_i = 1'b0;
    chk({tag, ".xfer"}, 64'({out_valid_o, in_ready_o, busy_o}), 64'b010);
  endtask

  initial begin
    bit quiet;
    #2 rst_n = 1'b0;
    #1;
    chk("rst.flags", 64'({in_ready_o, out_valid_o, busy_o}), 64'b000);
    chk("rst.prod", product_o, 64'd0);
    repeat (3) @(posedge CLK);
    @(negedge CLK) rst_n = 1'b1;
    #1;
    chk("rel.rdy0", 64'(in_ready_o), 64'd0);
    @(posedge CLK); #1;
    chk("rel.rdy1", 64'(in_ready_o), 64'd1);

    do_mul("3x5", 32'd3, 32'd5, 64'd15, 0);
    do_mul("m1xm1", 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd1, 0);
    do_mul("minxm1", 32'h80000000, 32'hFFFFFFFF,
           64'h0000000080000000, 0);
    do_mul("minxmin", 32'h80000000, 32'h80000000,
           64'h4000000000000000, 0);
    do_mul("maxxmax", 32'h7FFFFFFF, 32'h7FFFFFFF,
           64'h3FFFFFFF00000001, 5);
    do_mul("x0", 32'h12345678, 32'h0, 64'd0, 0);
    do_mul("mix", 32'h00012345, 32'hFFFFFFFE,
           64'hFFFFFFFFFFFDB976, 0);

    wait_ready();
    a_i = 32'h11111111;
    b_i = 32'h22222222;
    in_valid_i = 1'b1;
    @(posedge CLK); #1;
    in_valid_i = 1'b0;
    repeat (7) @(posedge CLK);
    #2 rst_n = 1'b0;
    #1;
    chk("abort.flags", 64'({in_ready_o, out_valid_o, busy_o}), 64'b000);
    chk("abort.prod", product_o, 64'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK) rst_n = 1'b1;
    #1;
    chk("abort.rdy0", 64'(in_ready_o), 64'd0);
    quiet = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); #1;
      if (out_valid_o || busy_o) quiet = 1'b0;
    end
    chk("abort.quiet", 64'(quiet), 64'd1);

    do_mul("m7x9", 32'hFFFFFFF9, 32'd9, 64'hFFFFFFFFFFFFFFC1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/booth4_seq_mul.md
BOOTH4_SEQ_MUL -- requirements
Module: booth4_seq_mul

Interface
REQ-001 SHALL have parameter LENGTH, default 32, operand width (even, >=4).
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid_i  input  1  operand pair valid.
REQ-005 SHALL have port in_ready_o  output  1  block can accept operands (high only in IDLE).
REQ-006 SHALL have port a_i  input  LENGTH  multiplicand, two's complement.
REQ-007 SHALL have port b_i  input  LENGTH  multiplier, two's complement.
REQ-008 SHALL have port out_valid_o  output  1  product valid.
REQ-009 SHALL have port out_ready_i  input  1  consumer accepts product.
REQ-010 SHALL have port product_o  output  2*LENGTH  signed product a_i*b_i.
REQ-011 SHALL have port busy_o  output  1  high in RUN or DONE.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 In IDLE, in_valid_i && in_ready_o SHALL latch a_i, b_i, clear accumulator and step counter, and move to RUN; in_valid_i outside IDLE SHALL be ignored.
REQ-014 RUN SHALL last exactly LENGTH/2 cycles, step k = 0..LENGTH/2-1, one radix-4 Booth digit per cycle.
REQ-015 Step k SHALL select window {b[2k+1], b[2k], b[2k-1]} with b[-1] = 0.
REQ-016 Digit mapping SHALL be 000/111 -> 0, 001/010 -> +A, 011 -> +2A, 100 -> -2A, 101/110 -> -A.
REQ-017 Partial product SHALL be generated from multiplicand sign-extended to LENGTH+1 bits, giving a LENGTH+2-bit result, so A = -2^(LENGTH-1) with digit -2A is exact.
REQ-018 Step k SHALL add the partial product, sign-extended to 2*LENGTH bits and shifted left 2k, to the accumulator modulo 2^(2*LENGTH).
REQ-019 After step LENGTH/2-1 the FSM SHALL move to DONE; out_valid_o SHALL go high on the next cycle, for a latency of LENGTH/2+1 cycles from acceptance to out_valid_o.
REQ-020 In DONE, product_o SHALL hold stable while out_ready_i is low.
REQ-021 In DONE, out_ready_i high SHALL complete the transfer and return the FSM to IDLE next cycle; a new operand is accepted no earlier than that IDLE cycle.
REQ-022 product_o SHALL equal the exact signed product for all operand pairs, including the most-negative times most-negative case.
REQ-023 out_valid_o SHALL be low in IDLE and RUN; in_ready_o SHALL be low in RUN and DONE.
REQ-024 Outputs SHALL be registered, with no combinational path from in_valid_i or out_ready_i to any output.

Reset
REQ-025 rst_n low SHALL asynchronously force IDLE, accumulator = 0, step counter = 0, operand registers = 0.
REQ-026 While rst_n is low, outputs SHALL be in_ready_o = 0, out_valid_o = 0, busy_o = 0, product_o = 0.
REQ-027 in_ready_o SHALL go high on the first clock edge after rst_n deasserts.
REQ-028 Reset asserted mid-RUN or mid-DONE SHALL abort the operation with no out_valid_o pulse afterwards.

Structure
REQ-029 FSM state encoding and Booth digit codes SHALL reside in shared package f_mul_pkg.
REQ-030 Partial-product generation SHALL be one sub-module instance, booth4code_gold, with length = LENGTH+1.
REQ-031 The step counter SHALL be $clog2(LENGTH/2) bits wide; the multiplier SHALL be held in a register shifted right 2 bits per step, with a separate bit holding b[2k-1].

Verification
REQ-032 LENGTH=32, a=3, b=5, out_ready_i=1 -> product_o = 15, out_valid_o rising 17 cycles after acceptance.
REQ-033 a=0xFFFFFFFF, b=0xFFFFFFFF -> product_o = 1; a=0x80000000, b=0xFFFFFFFF -> product_o = 0x0000000080000000.
REQ-034 a=b=0x80000000 -> product_o = 0x4000000000000000.
REQ-035 out_ready_i held low 5 cycles in DONE -> product_o stable and out_valid_o high throughout; in_valid_i pulses during RUN/DONE are ignored.
REQ-036 rst_n pulsed low at step 7 of RUN -> all outputs 0 immediately; after release, new a=-7, b=9 -> product_o = -63 (0xFFFFFFFFFFFFFFC1).
